// File: rtl/pb_conditioner.sv
// pb_conditioner
//   Pushbutton front end: 2-flop synchronizer, counter-based debounce, and a
//   registered pulse FSM that produces press, auto-repeat and release pulses.
//
// Ports
//   CLK   in   system clock, rising edge
//   RST   in   synchronous reset, active-low
//   PB    in   raw asynchronous pushbutton level, active-high
//   PBdb  out  debounced, synchronized button level
//   ENos  out  1-cycle pulse on press and on each auto-repeat
//   REL   out  1-cycle pulse on debounced release
//   HELD  out  high while the FSM is in REPEAT
//
// Pulse FSM states
//   state   | meaning
//   IDLE    | button released, waiting for PBdb to rise
//   PRESSED | press pulse issued, timing the hold delay (hcnt)
//   REPEAT  | auto-repeating every REPEAT_CYCLES (rcnt), HELD high
module pb_conditioner #(
  parameter int DB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic PB,
  output logic PBdb,
  output logic ENos,
  output logic REL,
  output logic HELD
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DB_TC   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic          s1, s2;
  logic [DW-1:0] dcnt;

  state_t        state, state_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic          en_nx, rel_nx, held_nx;

  // Synchronizer and debounce. Any bounce back to the accepted level clears
  // the counter, so only an unbroken run of DB_CYCLES samples is accepted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      PBdb <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= PB;
      s2 <= s1;
      if (s2 == PBdb) begin
        dcnt <= '0;
      end else if (dcnt == DB_TC) begin
        PBdb <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      hcnt  <= '0;
      rcnt  <= '0;
      ENos  <= 1'b0;
      REL   <= 1'b0;
      HELD  <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
      rcnt  <= rcnt_nx;
      ENos  <= en_nx;
      REL   <= rel_nx;
      HELD  <= held_nx;
    end
  end

  // Release is checked before any repeat so a release coinciding with a due
  // repeat yields REL only.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    rcnt_nx  = rcnt;
    en_nx    = 1'b0;
    rel_nx   = 1'b0;
    held_nx  = HELD;
    case (state)
      IDLE: begin
        if (PBdb) begin
          en_nx    = 1'b1;
          hcnt_nx  = '0;
          state_nx = PRESSED;
        end
      end
      PRESSED: begin
        if (!PBdb) begin
          rel_nx   = 1'b1;
          held_nx  = 1'b0;
          hcnt_nx  = '0;
          rcnt_nx  = '0;
          state_nx = IDLE;
        end else if (hcnt == HOLD_TC) begin
          // Without auto-repeat hcnt simply parks at its terminal value.
          if (REPEAT_EN) begin
            en_nx    = 1'b1;
            held_nx  = 1'b1;
            rcnt_nx  = '0;
            state_nx = REPEAT;
          end
        end else begin
          hcnt_nx = hcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!PBdb) begin
          rel_nx   = 1'b1;
          held_nx  = 1'b0;
          hcnt_nx  = '0;
          rcnt_nx  = '0;
          state_nx = IDLE;
        end else if (rcnt == REP_TC) begin
          en_nx   = 1'b1;
          rcnt_nx = '0;
        end else begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
      default: begin
        held_nx  = 1'b0;
        hcnt_nx  = '0;
        rcnt_nx  = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with DB_CYCLES=4, HOLD_CYCLES=10,
// REPEAT_CYCLES=3, REPEAT_EN=1. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after each edge, so the value seen
// after step k is the value registered at edge k.
module tb_pb_conditioner;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic PB  = 1'b0;
  logic PBdb, ENos, REL, HELD;

  int n_checks = 0;
  int n_fail   = 0;

  pb_conditioner #(
    .DB_CYCLES    (4),
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(3),
    .REPEAT_EN    (1'b1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .PB  (PB),
    .PBdb(PBdb),
    .ENos(ENos),
    .REL (REL),
    .HELD(HELD)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input int k,
                           input logic e_db, input logic e_en,
                           input logic e_rel, input logic e_held);
    check({tag, ".PBdb"}, k, PBdb, e_db);
    check({tag, ".ENos"}, k, ENos, e_en);
    check({tag, ".REL"},  k, REL,  e_rel);
    check({tag, ".HELD"}, k, HELD, e_held);
  endtask

  initial begin
    logic e_db, e_en, e_rel, e_held;

    // 1: reset held with PB high
    RST = 1'b0;
    PB  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_all("reset", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 2: glitch of 3 cycles (one short of DB_CYCLES) is rejected
    RST = 1'b1;
    PB  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) PB = 1'b0;
      check_all("glitch", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    assert (dut.dcnt === 3'd0) else begin
      n_fail++;
      $error("FAIL glitch.dcnt observed=%0d expected=0", dut.dcnt);
    end

    // 3/4/5: press, hold into repeat, release timed so REL coincides with a
    // due repeat (edge 32). PB high for edges 1..25, low from edge 26.
    PB = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 25) PB = 1'b0;
      e_db   = (k >= 6) && (k < 31);
      e_en   = (k == 7) || (k == 17) || (k == 20) || (k == 23) ||
               (k == 26) || (k == 29);
      e_rel  = (k == 32);
      e_held = (k >= 17) && (k < 32);
      check_all("press", k, e_db, e_en, e_rel, e_held);
    end

    // 6: reset in the middle of REPEAT with PB held, then a fresh press
    PB = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      e_db   = (k >= 6);
      e_en   = (k == 7) || (k == 17) || (k == 20);
      e_held = (k >= 17);
      check_all("prerst", k, e_db, e_en, 1'b0, e_held);
    end
    RST = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      check_all("midrst", k, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    RST = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      e_db = (k >= 6);
      e_en = (k == 7);
      check_all("repress", k, e_db, e_en, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
